// File: rtl/hub75_panel_rx_pkg.sv
// Shared types and constants for the HUB75 panel receiver.
// Panel geometry: one row of PIXEL_WIDTH pixels per latch. Each pixel is a
// 6-bit {r2,g2,b2,r1,g1,b1} word. Brightness is PLANES bit-planes deep.
package hub75_panel_rx_pkg;

    localparam int PIXEL_WIDTH = 64;
    localparam int ROW_ADDR_W  = 4;

    typedef logic [ROW_ADDR_W-1:0]          row_subpanel_addr_t;
    typedef logic [$clog2(PIXEL_WIDTH)-1:0] col_addr_t;
    typedef logic [7:0]                     brightness_level_t;

    localparam int PLANES      = $bits(brightness_level_t);
    localparam int PLANE_IDX_W = $clog2(PLANES);
    localparam int SHIFT_CNT_W = $clog2(PIXEL_WIDTH + 1);

    typedef logic [PLANE_IDX_W-1:0] plane_idx_t;
    typedef logic [5:0]             hub_rgb_t;

    typedef struct packed {
        row_subpanel_addr_t row;
        col_addr_t          col;
        plane_idx_t         plane;
        hub_rgb_t           rgb;
    } pixel_wr_t;

    typedef enum logic {
        SER_IDLE = 1'b0,
        SER_SEND = 1'b1
    } ser_state_t;

endpackage

// File: rtl/hub75_panel_rx_input_sync.sv
// Single-bit synchroniser with a rising-edge detect.
// Ports:
//   clk_in  : sampling clock
//   reset_n : asynchronous active-low reset
//   d_i     : asynchronous input bit
//   rise_o  : one-cycle pulse when the synchronised level goes 0 -> 1
// The pulse occurs in the same cycle the synchronised level first reads
// high, so it stays aligned with other buses synchronised to the same depth.
module hub75_input_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk_in,
    input  logic reset_n,
    input  logic d_i,
    output logic rise_o
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prev_q;

    always_ff @(posedge clk_in or negedge reset_n) begin
        if (!reset_n) begin
            sync_q <= '0;
            prev_q <= 1'b0;
        end else begin
            for (int i = SYNC_STAGES - 1; i > 0; i--) begin
                sync_q[i] <= sync_q[i-1];
            end
            sync_q[0] <= d_i;
            prev_q    <= sync_q[SYNC_STAGES-1];
        end
    end

    assign rise_o = sync_q[SYNC_STAGES-1] & ~prev_q;

endmodule

// File: rtl/hub75_panel_rx.sv
// HUB75 panel receiver: oversamples the panel pins, shifts in one row per
// latch, tracks row/bit-plane sequencing, measures OE on-time per plane and
// streams the latched row out as per-column write words.
// Ports:
//   clk_in, reset_n          : system clock, async active-low reset
//   hub_clk/lat/oe/row/rgb   : raw HUB75 pins (asynchronous to clk_in)
//   wr_valid/ready, wr_*     : write-word stream, column 0 first
//   oe_stat_valid/plane/cycles : per-plane OE on-time report at each latch
//   err_count, err_overrun   : sticky error flags, cleared by err_clear
module hub75_panel_rx
    import hub75_panel_rx_pkg::*;
#(
    parameter int SYNC_STAGES    = 2,
    parameter bit OE_ACTIVE_LOW  = 1'b1,
    parameter int OE_COUNT_WIDTH = 16
) (
    input  logic                      clk_in,
    input  logic                      reset_n,
    input  logic                      hub_clk,
    input  logic                      hub_lat,
    input  logic                      hub_oe,
    input  row_subpanel_addr_t        hub_row,
    input  hub_rgb_t                  hub_rgb,
    output logic                      wr_valid,
    input  logic                      wr_ready,
    output row_subpanel_addr_t        wr_row,
    output col_addr_t                 wr_col,
    output plane_idx_t                wr_plane,
    output hub_rgb_t                  wr_rgb,
    output logic                      oe_stat_valid,
    output plane_idx_t                oe_stat_plane,
    output logic [OE_COUNT_WIDTH-1:0] oe_stat_cycles,
    output logic                      err_count,
    output logic                      err_overrun,
    input  logic                      err_clear
);

    localparam int DATA_W = 1 + $bits(row_subpanel_addr_t) + $bits(hub_rgb_t);

    // Data-bus synchroniser; same depth as the edge detectors' level path.
    logic [DATA_W-1:0]  data_sync_q [SYNC_STAGES];
    logic               oe_s;
    row_subpanel_addr_t row_s;
    hub_rgb_t           rgb_s;
    logic               oe_active;
    logic               clk_rise;
    logic               lat_rise;

    always_ff @(posedge clk_in or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < SYNC_STAGES; i++) data_sync_q[i] <= '0;
        end else begin
            for (int i = SYNC_STAGES - 1; i > 0; i--) data_sync_q[i] <= data_sync_q[i-1];
            data_sync_q[0] <= {hub_oe, hub_row, hub_rgb};
        end
    end

    assign {oe_s, row_s, rgb_s} = data_sync_q[SYNC_STAGES-1];
    assign oe_active = OE_ACTIVE_LOW ? ~oe_s : oe_s;

    hub75_input_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_clk (
        .clk_in (clk_in),
        .reset_n(reset_n),
        .d_i    (hub_clk),
        .rise_o (clk_rise)
    );

    hub75_input_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_lat (
        .clk_in (clk_in),
        .reset_n(reset_n),
        .d_i    (hub_lat),
        .rise_o (lat_rise)
    );

    // Shift path. shift_cnt_d already includes a shift in this cycle, so a
    // pixel clock coinciding with the latch is counted in the latched row.
    logic [SHIFT_CNT_W-1:0] shift_cnt_q, shift_cnt_d;
    logic                   shift_take;
    hub_rgb_t               shift_buf_q [PIXEL_WIDTH];
    hub_rgb_t               out_buf_q   [PIXEL_WIDTH];   // indexed by pixel k

    assign shift_take  = clk_rise && (shift_cnt_q < SHIFT_CNT_W'(PIXEL_WIDTH));
    assign shift_cnt_d = shift_take ? shift_cnt_q + 1'b1 : shift_cnt_q;

    // Row / plane tracking
    row_subpanel_addr_t prev_row_q, out_row_q;
    plane_idx_t         plane_q, plane_d, out_plane_q;

    always_comb begin
        plane_d = plane_q;
        if (row_s != prev_row_q || plane_q == '0) begin
            plane_d = plane_idx_t'(PLANES - 1);
        end else begin
            plane_d = plane_q - 1'b1;
        end
    end

    // Serializer
    ser_state_t state_q, state_d;
    col_addr_t  col_q, col_d;
    logic       capture;

    assign capture = lat_rise && (state_q == SER_IDLE);

    always_comb begin
        state_d = state_q;
        col_d   = col_q;
        case (state_q)
            SER_IDLE: begin
                if (capture) begin
                    state_d = SER_SEND;
                    col_d   = '0;
                end
            end
            SER_SEND: begin
                if (wr_ready) begin
                    col_d = col_addr_t'(col_q + 1'b1);
                    if (col_q == col_addr_t'(PIXEL_WIDTH - 1)) state_d = SER_IDLE;
                end
            end
            default: state_d = SER_IDLE;
        endcase
    end

    logic [OE_COUNT_WIDTH-1:0] oe_cnt_q;
    logic                      seen_lat_q;

    always_ff @(posedge clk_in or negedge reset_n) begin
        if (!reset_n) begin
            shift_cnt_q    <= '0;
            for (int i = 0; i < PIXEL_WIDTH; i++) begin
                shift_buf_q[i] <= '0;
                out_buf_q[i]   <= '0;
            end
            prev_row_q     <= '0;
            plane_q        <= plane_idx_t'(PLANES - 1);
            out_row_q      <= '0;
            out_plane_q    <= '0;
            state_q        <= SER_IDLE;
            col_q          <= '0;
            err_count      <= 1'b0;
            err_overrun    <= 1'b0;
            oe_cnt_q       <= '0;
            seen_lat_q     <= 1'b0;
            oe_stat_valid  <= 1'b0;
            oe_stat_plane  <= '0;
            oe_stat_cycles <= '0;
        end else begin
            state_q     <= state_d;
            col_q       <= col_d;
            shift_cnt_q <= lat_rise ? '0 : shift_cnt_d;

            for (int i = 0; i < PIXEL_WIDTH; i++) begin
                if (shift_take && shift_cnt_q == SHIFT_CNT_W'(i)) shift_buf_q[i] <= rgb_s;
                // Unshifted pixels are forced to 0 rather than leaking the previous row.
                if (capture) begin
                    if (SHIFT_CNT_W'(i) < shift_cnt_d) begin
                        out_buf_q[i] <= (shift_take && shift_cnt_q == SHIFT_CNT_W'(i))
                                        ? rgb_s : shift_buf_q[i];
                    end else begin
                        out_buf_q[i] <= '0;
                    end
                end
            end

            if (lat_rise) begin
                plane_q    <= plane_d;
                prev_row_q <= row_s;
            end
            if (capture) begin
                out_row_q   <= row_s;
                out_plane_q <= plane_d;
            end

            // Error event takes priority over a simultaneous clear.
            if (lat_rise && shift_cnt_d != SHIFT_CNT_W'(PIXEL_WIDTH)) err_count <= 1'b1;
            else if (err_clear)                                       err_count <= 1'b0;
            if (lat_rise && state_q != SER_IDLE) err_overrun <= 1'b1;
            else if (err_clear)                  err_overrun <= 1'b0;

            // OE on-time: the interval between two latches belongs to the
            // plane latched at the start of it (plane_q before update).
            if (lat_rise) begin
                oe_cnt_q       <= '0;
                seen_lat_q     <= 1'b1;
                oe_stat_valid  <= seen_lat_q;
                oe_stat_plane  <= plane_q;
                oe_stat_cycles <= oe_cnt_q;
            end else begin
                oe_stat_valid <= 1'b0;
                if (oe_active && oe_cnt_q != '1) oe_cnt_q <= oe_cnt_q + 1'b1;
            end
        end
    end

    assign wr_valid = (state_q == SER_SEND);
    assign wr_row   = out_row_q;
    assign wr_col   = col_q;
    assign wr_plane = out_plane_q;
    assign wr_rgb   = out_buf_q[col_addr_t'(PIXEL_WIDTH - 1) - col_q];

endmodule

// File: tb/tb_hub75_panel_rx.sv
module tb_hub75_panel_rx;
    import hub75_panel_rx_pkg::*;

    logic clk_in = 1'b0;
    logic reset_n, hub_clk, hub_lat, hub_oe, wr_ready, err_clear;
    row_subpanel_addr_t hub_row;
    hub_rgb_t hub_rgb;

    logic wr_valid, oe_stat_valid, err_count, err_overrun;
    row_subpanel_addr_t wr_row;
    col_addr_t wr_col;
    plane_idx_t wr_plane, oe_stat_plane;
    hub_rgb_t wr_rgb;
    logic [15:0] oe_stat_cycles;

    logic wr_valid4, oe_stat_valid4, err_count4, err_overrun4;
    row_subpanel_addr_t wr_row4;
    col_addr_t wr_col4;
    plane_idx_t wr_plane4, oe_stat_plane4;
    hub_rgb_t wr_rgb4;
    logic [3:0] oe_stat_cycles4;

    always #5 clk_in = ~clk_in;

    hub75_panel_rx dut (
        .clk_in(clk_in), .reset_n(reset_n), .hub_clk(hub_clk), .hub_lat(hub_lat),
        .hub_oe(hub_oe), .hub_row(hub_row), .hub_rgb(hub_rgb),
        .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_row(wr_row), .wr_col(wr_col),
        .wr_plane(wr_plane), .wr_rgb(wr_rgb), .oe_stat_valid(oe_stat_valid),
        .oe_stat_plane(oe_stat_plane), .oe_stat_cycles(oe_stat_cycles),
        .err_count(err_count), .err_overrun(err_overrun), .err_clear(err_clear)
    );

    hub75_panel_rx #(.OE_COUNT_WIDTH(4)) dut4 (
        .clk_in(clk_in), .reset_n(reset_n), .hub_clk(hub_clk), .hub_lat(hub_lat),
        .hub_oe(hub_oe), .hub_row(hub_row), .hub_rgb(hub_rgb),
        .wr_valid(wr_valid4), .wr_ready(wr_ready), .wr_row(wr_row4), .wr_col(wr_col4),
        .wr_plane(wr_plane4), .wr_rgb(wr_rgb4), .oe_stat_valid(oe_stat_valid4),
        .oe_stat_plane(oe_stat_plane4), .oe_stat_cycles(oe_stat_cycles4),
        .err_count(err_count4), .err_overrun(err_overrun4), .err_clear(err_clear)
    );

    int checks = 0;
    int failures = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    pixel_wr_t exp_q[$];
    pixel_wr_t acc_log[$];
    int        st_plane_q[$];
    int        st_cyc_q[$];
    hub_rgb_t  m_pix [PIXEL_WIDTH];
    int        m_n;
    int        m_plane;
    int        m_prev_row;
    bit        m_err_count, m_err_overrun;
    int        last_st_plane, last_st_cyc, last_st_cyc4;
    int        ready_mode;   // 0 always ready, 1 random, 2 stalled
    bit        oe_rand;

    task automatic model_reset();
        exp_q.delete();
        st_plane_q.delete();
        st_cyc_q.delete();
        m_plane = PLANES - 1;
        m_prev_row = 0;
        m_err_count = 0;
        m_err_overrun = 0;
    endtask

    // OE on-time model on the raw pins: count OE-low cycles between latch rises.
    initial begin
        int  acc = 0;
        bit  seen = 0;
        bit  lat_prev = 0;
        int  lat_plane = 0;
        forever begin
            @(posedge clk_in);
            if (!reset_n) begin
                acc = 0; seen = 0; lat_prev = 0;
            end else begin
                if (hub_lat && !lat_prev) begin
                    if (seen) begin
                        st_plane_q.push_back(lat_plane);
                        st_cyc_q.push_back(acc);
                    end
                    seen = 1;
                    acc = 0;
                    lat_plane = m_plane;
                end else if (hub_oe == 1'b0) begin
                    acc++;
                end
                lat_prev = hub_lat;
            end
        end
    end

    // Compare process: checks every presented word and every stat pulse.
    initial begin
        pixel_wr_t w;
        int ep, ec;
        forever begin
            @(negedge clk_in);
            if (reset_n) begin
                if (wr_valid || wr_valid4) begin
                    if (exp_q.size() == 0) begin
                        check("spurious_word", 1, 0);
                    end else begin
                        w = exp_q[0];
                        check("wr_word", {wr_valid, wr_row, wr_col, wr_plane, wr_rgb}, {1'b1, w});
                        check("wr_word4", {wr_valid4, wr_row4, wr_col4, wr_plane4, wr_rgb4}, {1'b1, w});
                        if (wr_ready) begin
                            acc_log.push_back(pixel_wr_t'({wr_row, wr_col, wr_plane, wr_rgb}));
                            void'(exp_q.pop_front());
                        end
                    end
                end
                if (oe_stat_valid || oe_stat_valid4) begin
                    if (st_plane_q.size() == 0) begin
                        check("spurious_stat", 1, 0);
                    end else begin
                        ep = st_plane_q.pop_front();
                        ec = st_cyc_q.pop_front();
                        check("oe_stat", {oe_stat_valid, oe_stat_plane, oe_stat_cycles},
                              {1'b1, plane_idx_t'(ep), 16'(ec > 65535 ? 65535 : ec)});
                        check("oe_stat4", {oe_stat_valid4, oe_stat_plane4, oe_stat_cycles4},
                              {1'b1, plane_idx_t'(ep), 4'(ec > 15 ? 15 : ec)});
                        last_st_plane = int'(oe_stat_plane);
                        last_st_cyc   = int'(oe_stat_cycles);
                        last_st_cyc4  = int'(oe_stat_cycles4);
                    end
                end
            end
        end
    end

    // Background drivers (change just after the rising edge).
    initial forever begin
        @(posedge clk_in); #1;
        case (ready_mode)
            0:       wr_ready = 1'b1;
            1:       wr_ready = 1'($urandom_range(0, 1));
            default: wr_ready = 1'b0;
        endcase
    end

    initial forever begin
        @(posedge clk_in); #1;
        if (oe_rand) hub_oe = 1'($urandom_range(0, 1));
    end

    // ---------------- stimulus tasks ----------------
    task automatic tick(input int n);
        repeat (n) begin @(posedge clk_in); #1; end
    endtask

    task automatic shift_row(input int n, input bit ramp);
        hub_rgb_t v;
        for (int k = 0; k < PIXEL_WIDTH; k++) m_pix[k] = '0;
        for (int k = 0; k < n; k++) begin
            v = ramp ? hub_rgb_t'(k) : hub_rgb_t'($urandom);
            if (k < PIXEL_WIDTH) m_pix[k] = v;
            hub_rgb = v;
            tick(2);
            hub_clk = 1'b1;
            tick(2);
            hub_clk = 1'b0;
        end
        m_n = n;
        tick(2);
    endtask

    task automatic wait_drain();
        int t = 0;
        while (exp_q.size() != 0 && t < 3000) begin tick(1); t++; end
        if (exp_q.size() != 0) begin
            check("drain_timeout", exp_q.size(), 0);
            exp_q.delete();
        end
        tick(2);
    endtask

    task automatic latch_row(input int row, input bit allow_overrun);
        pixel_wr_t w;
        bit busy;
        hub_row = row_subpanel_addr_t'(row);
        tick(4);
        if (!allow_overrun) wait_drain();
        busy = (exp_q.size() != 0);
        if (row != m_prev_row || m_plane == 0) m_plane = PLANES - 1;
        else m_plane = m_plane - 1;
        m_prev_row = row;
        if ((m_n > PIXEL_WIDTH ? PIXEL_WIDTH : m_n) != PIXEL_WIDTH) m_err_count = 1;
        if (busy) begin
            m_err_overrun = 1;
        end else begin
            for (int c = 0; c < PIXEL_WIDTH; c++) begin
                w.row   = row_subpanel_addr_t'(row);
                w.col   = col_addr_t'(c);
                w.plane = plane_idx_t'(m_plane);
                w.rgb   = m_pix[PIXEL_WIDTH - 1 - c];
                exp_q.push_back(w);
            end
        end
        $display("latch row=%0d plane=%0d pixels=%0d dropped=%0d", row, m_plane, m_n, busy);
        hub_lat = 1'b1;
        tick(3);
        hub_lat = 1'b0;
        tick(3);
    endtask

    task automatic check_flags(input string tag);
        tick(2);
        check({tag, "_err_count"}, {err_count, err_count4}, {m_err_count, m_err_count});
        check({tag, "_err_overrun"}, {err_overrun, err_overrun4}, {m_err_overrun, m_err_overrun});
    endtask

    task automatic clear_errors();
        err_clear = 1'b1;
        tick(1);
        err_clear = 1'b0;
        m_err_count = 0;
        m_err_overrun = 0;
        check_flags("clear");
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    // ---------------- test sequence ----------------
    initial begin
        int t;
        pixel_wr_t w;
        reset_n = 1'b0; hub_clk = 0; hub_lat = 0; hub_oe = 1'b1; hub_row = '0; hub_rgb = '0;
        wr_ready = 1'b1; err_clear = 0; ready_mode = 0; oe_rand = 0; m_n = 0;
        last_st_plane = -1; last_st_cyc = -1; last_st_cyc4 = -1;
        model_reset();
        tick(5);
        check("reset_outputs", {wr_valid, err_count, err_overrun, oe_stat_valid, wr_rgb, wr_plane, wr_col},
              '0);
        reset_n = 1'b1;
        tick(3);

        // 1: ramp row on row 3
        oe_rand = 1;
        acc_log.delete();
        shift_row(64, 1);
        latch_row(3, 0);
        wait_drain();
        check_flags("t1");
        check("t1_words", acc_log.size(), 64);
        w = '{row: 4'd3, col: 6'd0, plane: 3'd7, rgb: 6'd63};
        check("t1_first_word", acc_log[0], w);
        w = '{row: 4'd3, col: 6'd63, plane: 3'd7, rgb: 6'd0};
        check("t1_last_word", acc_log[63], w);

        // 2: plane count-down on row 3, then row 4
        ready_mode = 1;
        for (int i = 0; i < PLANES; i++) begin
            acc_log.delete();
            shift_row(64, 0);
            latch_row(3, 0);
            wait_drain();
            if (i == 0) check("t2_plane_first", acc_log[0].plane, 6);
        end
        check("t2_plane_wrap", acc_log[0].plane, 7);
        acc_log.delete();
        shift_row(64, 0);
        latch_row(4, 0);
        wait_drain();
        check("t2_row4_plane", {acc_log[0].row, acc_log[0].plane}, {4'd4, 3'd7});

        // 3: stall mid-row then random ready
        acc_log.delete();
        shift_row(64, 0);
        latch_row(4, 0);
        t = 0;
        while (acc_log.size() < 20 && t < 1000) begin tick(1); t++; end
        ready_mode = 2;
        tick(10);
        ready_mode = 1;
        wait_drain();
        check("t3_accepts", acc_log.size(), 64);

        // 4: short row
        acc_log.delete();
        shift_row(60, 0);
        latch_row(4, 0);
        check_flags("t4");
        wait_drain();
        for (int c = 0; c < 4; c++) check("t4_zero_col", {acc_log[c].col, acc_log[c].rgb}, {6'(c), 6'd0});
        clear_errors();

        // 5: overrun while stalled
        acc_log.delete();
        ready_mode = 2;
        shift_row(64, 0);
        latch_row(6, 0);
        shift_row(64, 0);
        latch_row(6, 1);
        check_flags("t5");
        ready_mode = 1;
        wait_drain();
        tick(20);
        check("t5_accepts", acc_log.size(), 64);
        clear_errors();

        // 6: OE on-time measurement
        oe_rand = 0;
        hub_oe = 1'b1;
        shift_row(64, 0);
        latch_row(9, 0);
        tick(5);
        hub_oe = 1'b0;
        tick(200);
        hub_oe = 1'b1;
        shift_row(64, 0);
        latch_row(9, 0);
        tick(4);
        check("t6_oe_cycles", last_st_cyc, 200);
        check("t6_oe_cycles4", last_st_cyc4, 15);
        check("t6_oe_plane", last_st_plane, 7);

        // reset mid-drain
        acc_log.delete();
        oe_rand = 1;
        shift_row(64, 0);
        latch_row(2, 0);
        t = 0;
        while (acc_log.size() < 5 && t < 1000) begin tick(1); t++; end
        @(negedge clk_in); #2;
        reset_n = 1'b0;
        #1;
        check("reset_async_valid", {wr_valid, wr_valid4}, 2'b00);
        model_reset();
        tick(3);
        reset_n = 1'b1;
        tick(100);
        check("post_reset_idle", {wr_valid, err_count, err_overrun}, 3'b000);

        // after reset row 0 equals the reset prev_row, so the plane steps down
        acc_log.delete();
        shift_row(64, 0);
        latch_row(0, 0);
        wait_drain();
        check("post_reset_plane", acc_log[0].plane, 6);
        check_flags("final");
        tick(10);
        check("stat_queue_empty", st_plane_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
